// File: rtl/branch_resolver.sv
// Compares EX-resolved control transfers with fetch-time BTB predictions; a mispredict raises redirect one cycle later, held until flush_ack.
// BTB refills queue in a FIFO drained one per cycle on btb_wr_ready; res_stall while full. BRANCH_RESOLVER_STAT_EN adds stat counters.
module branch_resolver #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic                  res_is_jump,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_pc,
    input  logic [ADDR_WIDTH-1:0] res_target,
    input  logic                  pred_hit,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  res_stall,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  flush_ack,
    input  logic                  btb_wr_ready,
    output logic                  btb_is_branch,
    output logic                  btb_is_jump,
    output logic [ADDR_WIDTH-1:0] btb_inst_pc,
    output logic [ADDR_WIDTH-1:0] btb_target
`ifdef BRANCH_RESOLVER_STAT_EN
    ,
    output logic [31:0]           stat_resolved,
    output logic [31:0]           stat_mispredict
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

    typedef enum logic {IDLE, REDIRECT} state_t;

    typedef struct packed {
        logic                  is_jump;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
    } upd_t;

    state_t          state;
    upd_t            mem [FIFO_DEPTH];
    upd_t            head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            empty;
    logic            actual_taken;
    logic            target_diff;
    logic            mispredict;
    logic            accept;
    logic            push;
    logic            pop;
    logic [ADDR_WIDTH-1:0] fix_pc;

    assign actual_taken = res_is_jump | res_taken;
    assign target_diff  = pred_target != res_target;
    assign mispredict   = (pred_hit != actual_taken) | (pred_hit & actual_taken & target_diff);
    assign fix_pc       = actual_taken ? res_target : res_pc + ADDR_WIDTH'(4);

    assign empty     = count == '0;
    assign res_stall = count == FULL_CNT;
    assign accept    = res_valid & ~res_stall & (state == IDLE);
    // A hit that resolves not-taken only redirects: the BTB cannot invalidate.
    assign push      = accept & actual_taken & (~pred_hit | target_diff);
    assign pop       = ~empty & btb_wr_ready;

    assign head          = mem[rd_ptr];
    assign btb_is_branch = pop;
    assign btb_is_jump   = ~empty & head.is_jump;
    assign btb_inst_pc   = empty ? '0 : head.pc;
    assign btb_target    = empty ? '0 : head.target;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{is_jump: res_is_jump, pc: res_pc, target: res_target};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mispredict) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= fix_pc;
                    end
                end
                REDIRECT: begin
                    // Resolutions seen here are wrong-path and never accepted.
                    if (flush_ack) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (accept)              stat_resolved   <= stat_resolved + 32'd1;
            if (accept && mispredict) stat_mispredict <= stat_mispredict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Table-driven bench for branch_resolver with a queue scoreboard on the BTB write port.
module tb_branch_resolver;
    logic        clk, rst;
    logic        res_valid, res_is_jump, res_taken, pred_hit, flush_ack, btb_wr_ready;
    logic [31:0] res_pc, res_target, pred_target;
    logic        res_stall, redirect_valid, btb_is_branch, btb_is_jump;
    logic [31:0] redirect_pc, btb_inst_pc, btb_target;
`ifdef BRANCH_RESOLVER_STAT_EN
    logic [31:0] stat_resolved, stat_mispredict;
`endif

    branch_resolver #(.ADDR_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_is_jump(res_is_jump), .res_taken(res_taken),
        .res_pc(res_pc), .res_target(res_target),
        .pred_hit(pred_hit), .pred_target(pred_target),
        .res_stall(res_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_ack(flush_ack), .btb_wr_ready(btb_wr_ready),
        .btb_is_branch(btb_is_branch), .btb_is_jump(btb_is_jump),
        .btb_inst_pc(btb_inst_pc), .btb_target(btb_target)
`ifdef BRANCH_RESOLVER_STAT_EN
        , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
    );

    typedef struct {
        logic        is_jump, taken, hit;
        logic [31:0] pc, tgt, ptgt;
        logic        mis;
        logic [31:0] rpc;
        logic        enq;
    } vec_t;

    vec_t        vt [9];
    logic [64:0] sb [$];
    logic [64:0] mon_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end within 500000 time units");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic j, input logic t, input logic h,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] ptgt);
        res_valid   = 1'b1;
        res_is_jump = j;
        res_taken   = t;
        pred_hit    = h;
        res_pc      = pc;
        res_target  = tgt;
        pred_target = ptgt;
    endtask

    // Cold-miss taken resolution: expect redirect to tgt, then acknowledge it.
    task automatic do_miss(input logic j, input logic [31:0] pc, input logic [31:0] tgt);
        drive(j, 1'b1, 1'b0, pc, tgt, 32'h0);
        sb.push_back({j, pc, tgt});
        tick;
        res_valid = 1'b0;
        @(negedge clk);
        chk("miss_redirect", {32'h0, redirect_valid, redirect_pc}, {32'h0, 1'b1, tgt});
        flush_ack = 1'b1;
        tick;
        flush_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && btb_is_branch) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL btb_unexpected: got write pc %h target %h, expected no write",
                         btb_inst_pc, btb_target);
            end else begin
                mon_exp = sb.pop_front();
                chk("btb_entry", {btb_is_jump, btb_inst_pc, btb_target}, mon_exp);
            end
        end
    end

    initial begin
        vt[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 32'h0000_2000, 1'b0, 32'h0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 1'b1, 32'h0000_2000, 1'b1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_2000, 32'h0000_2000, 1'b1, 32'h0000_1004, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_2000, 32'h0000_2000, 1'b1, 32'h0000_0000, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_1100, 32'h0000_2000, 32'h0000_2004, 1'b1, 32'h0000_2000, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_4000, 32'h0000_0000, 1'b1, 32'h0000_4000, 1'b1};
        vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h0000_6000, 32'h0000_0000, 1'b0, 32'h0, 1'b0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_5100, 32'h0000_6100, 32'h0000_6100, 1'b0, 32'h0, 1'b0};
        vt[8] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b1};

        rst = 1'b1; res_valid = 1'b0; res_is_jump = 1'b0; res_taken = 1'b0; pred_hit = 1'b0;
        res_pc = '0; res_target = '0; pred_target = '0; flush_ack = 1'b0; btb_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_redirect_valid", {64'h0, redirect_valid}, 65'h0);
        chk("rst_redirect_pc", {33'h0, redirect_pc}, 65'h0);
        chk("rst_stall", {64'h0, res_stall}, 65'h0);
        chk("rst_btb", {31'h0, btb_is_branch, btb_is_jump, btb_inst_pc}, 65'h0);
        chk("rst_btb_target", {33'h0, btb_target}, 65'h0);
        tick;

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].is_jump, vt[i].taken, vt[i].hit, vt[i].pc, vt[i].tgt, vt[i].ptgt);
            @(negedge clk);
            chk("vec_stall", {64'h0, res_stall}, 65'h0);
            if (vt[i].enq) sb.push_back({vt[i].is_jump, vt[i].pc, vt[i].tgt});
            tick;
            res_valid = 1'b0;
            @(negedge clk);
            chk("vec_redirect_valid", {64'h0, redirect_valid}, {64'h0, vt[i].mis});
            if (vt[i].mis) begin
                chk("vec_redirect_pc", {33'h0, redirect_pc}, {33'h0, vt[i].rpc});
                tick;
                flush_ack = 1'b1;
                @(negedge clk);
                chk("vec_redirect_held", {32'h0, redirect_valid, redirect_pc}, {32'h0, 1'b1, vt[i].rpc});
                tick;
                flush_ack = 1'b0;
                @(negedge clk);
                chk("vec_redirect_clear", {64'h0, redirect_valid}, 65'h0);
            end
            tick;
        end
`ifdef BRANCH_RESOLVER_STAT_EN
        chk("stat_resolved", {33'h0, stat_resolved}, 65'd9);
        chk("stat_mispredict", {33'h0, stat_mispredict}, 65'd6);
`endif

        // Wrong-path resolutions during REDIRECT, including the ack cycle.
        drive(1'b0, 1'b1, 1'b0, 32'h6000, 32'h7000, 32'h0);
        sb.push_back({1'b0, 32'h6000, 32'h7000});
        tick;
        drive(1'b0, 1'b1, 1'b0, 32'h6100, 32'h3000, 32'h0);
        @(negedge clk);
        chk("wp_redirect", {32'h0, redirect_valid, redirect_pc}, {32'h0, 1'b1, 32'h7000});
        tick;
        @(negedge clk);
        chk("wp_redirect_hold", {32'h0, redirect_valid, redirect_pc}, {32'h0, 1'b1, 32'h7000});
        tick;
        drive(1'b1, 1'b1, 1'b0, 32'h6200, 32'h3000, 32'h0);
        flush_ack = 1'b1;
        @(negedge clk);
        chk("wp_ack_cycle", {32'h0, redirect_valid, redirect_pc}, {32'h0, 1'b1, 32'h7000});
        tick;
        flush_ack = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        chk("wp_after_ack", {64'h0, redirect_valid}, 65'h0);
        tick;
        @(negedge clk);
        chk("wp_no_reredirect", {64'h0, redirect_valid}, 65'h0);
        tick;

        // Back-pressure: fill with the write port blocked, then drain.
        btb_wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) do_miss(1'b1, 32'(32'h100 * (k + 1)), 32'(32'h8000 + k * 16));
        @(negedge clk);
        chk("bp_full_stall", {64'h0, res_stall}, 65'h1);
        tick;
        drive(1'b1, 1'b1, 1'b0, 32'h900, 32'h9900, 32'h0);
        @(negedge clk);
        chk("bp_fifth_stall", {64'h0, res_stall}, 65'h1);
        tick;
        res_valid = 1'b0;
        @(negedge clk);
        chk("bp_fifth_no_redirect", {64'h0, redirect_valid}, 65'h0);
        tick;
        btb_wr_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain0", {63'h0, btb_is_branch, res_stall}, 65'h3);
        for (int k = 1; k < 4; k++) begin
            tick;
            @(negedge clk);
            chk("bp_drain", {63'h0, btb_is_branch, res_stall}, 65'h2);
        end
        tick;
        @(negedge clk);
        chk("bp_drained", {63'h0, btb_is_branch, res_stall}, 65'h0);
        tick;

        // Reset while redirecting with two queued updates.
        btb_wr_ready = 1'b0;
        do_miss(1'b0, 32'hA000, 32'hB000);
        drive(1'b0, 1'b1, 1'b0, 32'hA100, 32'hB100, 32'h0);
        sb.push_back({1'b0, 32'hA100, 32'hB100});
        tick;
        res_valid = 1'b0;
        @(negedge clk);
        chk("mr_pre_redirect", {32'h0, redirect_valid, redirect_pc}, {32'h0, 1'b1, 32'hB100});
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sb.delete();
        btb_wr_ready = 1'b1;
        @(negedge clk);
        chk("mr_redirect_valid", {64'h0, redirect_valid}, 65'h0);
        chk("mr_btb_empty", {31'h0, btb_is_branch, btb_is_jump, btb_inst_pc}, 65'h0);
        chk("mr_stall", {64'h0, res_stall}, 65'h0);
`ifdef BRANCH_RESOLVER_STAT_EN
        chk("mr_stats", {1'b0, stat_resolved, stat_mispredict}, 65'h0);
`endif
        for (int k = 0; k < 3; k++) begin
            tick;
            @(negedge clk);
            chk("mr_no_write", {64'h0, btb_is_branch}, 65'h0);
        end
        tick;
        chk("sb_drained", 65'(sb.size()), 65'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
